// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    localparam int unsigned REG_INDEX_SIZE = 5;

    typedef logic [REG_INDEX_SIZE-1:0] reg_index_t;

    // Fetch-response FSM: DROP discards a stale in-flight response
    typedef enum logic {
        PIPE_CTRL_RUN  = 1'b0,
        PIPE_CTRL_DROP = 1'b1
    } pipe_ctrl_state_e;

    // Winning stall source; the oldest stage has the highest priority
    typedef enum logic [2:0] {
        PIPE_CTRL_PRI_NONE  = 3'd0,
        PIPE_CTRL_PRI_REDIR = 3'd1,
        PIPE_CTRL_PRI_IF    = 3'd2,
        PIPE_CTRL_PRI_ID    = 3'd3,
        PIPE_CTRL_PRI_EX    = 3'd4,
        PIPE_CTRL_PRI_MEM   = 3'd5
    } pipe_ctrl_pri_e;

    function automatic logic reg_hit(
        input reg_index_t rs,
        input logic       used,
        input reg_index_t rd,
        input logic       wen
    );
        return used & wen & (rd != '0) & (rs == rd);
    endfunction

endpackage

// File: rtl/pipe_ctrl_haz.sv
// ID-stage hazard detection for dependencies the forwarding network cannot cover.
module pipe_ctrl_haz
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_INDEX_SIZE-1:0] i_rs1_index,
    input  logic [REG_INDEX_SIZE-1:0] i_rs2_index,
    input  logic                      i_rs1_used,
    input  logic                      i_rs2_used,
    input  logic [REG_INDEX_SIZE-1:0] i_id2ex_rd_index,
    input  logic                      i_id2ex_rd_wen,
    input  logic                      i_id2ex_inst_lui,
    input  logic [REG_INDEX_SIZE-1:0] i_ex2mem_rd_index,
    input  logic                      i_ex2mem_rd_wen,
    input  logic                      i_ex2mem_mem_read,
    output logic                      o_id_haz
);

    logic w_ex_hit;
    logic w_mem_hit;

    // Only LUI results forward out of EX; loads are not ready while in MEM
    assign w_ex_hit  = ~i_id2ex_inst_lui &
                       (reg_hit(i_rs1_index, i_rs1_used, i_id2ex_rd_index, i_id2ex_rd_wen) |
                        reg_hit(i_rs2_index, i_rs2_used, i_id2ex_rd_index, i_id2ex_rd_wen));
    assign w_mem_hit = i_ex2mem_mem_read &
                       (reg_hit(i_rs1_index, i_rs1_used, i_ex2mem_rd_index, i_ex2mem_rd_wen) |
                        reg_hit(i_rs2_index, i_rs2_used, i_ex2mem_rd_index, i_ex2mem_rd_wen));
    assign o_id_haz  = w_ex_hit | w_mem_hit;

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline, with stale-fetch drop FSM
// and a saturating stalled-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_INDEX_SIZE-1:0] pipe_ctrl_id_rs1_index_i,
    input  logic [REG_INDEX_SIZE-1:0] pipe_ctrl_id_rs2_index_i,
    input  logic                      pipe_ctrl_id_rs1_used_i,
    input  logic                      pipe_ctrl_id_rs2_used_i,
    input  logic [REG_INDEX_SIZE-1:0] pipe_ctrl_id2ex_rd_index_i,
    input  logic                      pipe_ctrl_id2ex_rd_wen_i,
    input  logic                      pipe_ctrl_id2ex_inst_lui_i,
    input  logic [REG_INDEX_SIZE-1:0] pipe_ctrl_ex2mem_rd_index_i,
    input  logic                      pipe_ctrl_ex2mem_rd_wen_i,
    input  logic                      pipe_ctrl_ex2mem_mem_read_i,
    input  logic                      pipe_ctrl_ex_busy_i,
    input  logic                      pipe_ctrl_mem_req_i,
    input  logic                      pipe_ctrl_mem_ready_i,
    input  logic                      pipe_ctrl_if_busy_i,
    input  logic                      pipe_ctrl_if_valid_i,
    input  logic                      pipe_ctrl_id_redirect_i,
    output logic                      pipe_ctrl_pc_stall_o,
    output logic                      pipe_ctrl_pc_redirect_o,
    output logic                      pipe_ctrl_if2id_stall_o,
    output logic                      pipe_ctrl_if2id_bubble_o,
    output logic                      pipe_ctrl_id2ex_stall_o,
    output logic                      pipe_ctrl_id2ex_bubble_o,
    output logic                      pipe_ctrl_ex2mem_stall_o,
    output logic                      pipe_ctrl_ex2mem_bubble_o,
    output logic                      pipe_ctrl_mem2wb_bubble_o,
    output logic [CNT_W-1:0]          pipe_ctrl_stall_cnt_o
);

    pipe_ctrl_state_e r_state;
    logic [CNT_W-1:0] r_stall_cnt;
    pipe_ctrl_pri_e   w_pri;
    logic             w_id_haz;
    logic             w_mem_stall;
    logic             w_ex_stall;
    logic             w_if_stall;
    logic             w_redir_ok;

    pipe_ctrl_haz u_haz (
        .i_rs1_index       (pipe_ctrl_id_rs1_index_i),
        .i_rs2_index       (pipe_ctrl_id_rs2_index_i),
        .i_rs1_used        (pipe_ctrl_id_rs1_used_i),
        .i_rs2_used        (pipe_ctrl_id_rs2_used_i),
        .i_id2ex_rd_index  (pipe_ctrl_id2ex_rd_index_i),
        .i_id2ex_rd_wen    (pipe_ctrl_id2ex_rd_wen_i),
        .i_id2ex_inst_lui  (pipe_ctrl_id2ex_inst_lui_i),
        .i_ex2mem_rd_index (pipe_ctrl_ex2mem_rd_index_i),
        .i_ex2mem_rd_wen   (pipe_ctrl_ex2mem_rd_wen_i),
        .i_ex2mem_mem_read (pipe_ctrl_ex2mem_mem_read_i),
        .o_id_haz          (w_id_haz)
    );

    assign w_mem_stall = pipe_ctrl_mem_req_i & ~pipe_ctrl_mem_ready_i;
    assign w_ex_stall  = pipe_ctrl_ex_busy_i;
    assign w_if_stall  = ~pipe_ctrl_if_valid_i | (r_state == PIPE_CTRL_DROP);
    assign w_redir_ok  = pipe_ctrl_id_redirect_i & ~w_id_haz & ~w_ex_stall & ~w_mem_stall;

    // An accepted redirect outranks a fetch stall: the PC loads the new target
    always_comb begin
        w_pri = PIPE_CTRL_PRI_NONE;
        if (w_mem_stall)     w_pri = PIPE_CTRL_PRI_MEM;
        else if (w_ex_stall) w_pri = PIPE_CTRL_PRI_EX;
        else if (w_id_haz)   w_pri = PIPE_CTRL_PRI_ID;
        else if (w_redir_ok) w_pri = PIPE_CTRL_PRI_REDIR;
        else if (w_if_stall) w_pri = PIPE_CTRL_PRI_IF;
    end

    // Each source holds everything upstream of it and bubbles the next stage down
    always_comb begin
        pipe_ctrl_pc_stall_o      = 1'b0;
        pipe_ctrl_pc_redirect_o   = 1'b0;
        pipe_ctrl_if2id_stall_o   = 1'b0;
        pipe_ctrl_if2id_bubble_o  = 1'b0;
        pipe_ctrl_id2ex_stall_o   = 1'b0;
        pipe_ctrl_id2ex_bubble_o  = 1'b0;
        pipe_ctrl_ex2mem_stall_o  = 1'b0;
        pipe_ctrl_ex2mem_bubble_o = 1'b0;
        pipe_ctrl_mem2wb_bubble_o = 1'b0;
        if (!rst) begin
            case (w_pri)
                PIPE_CTRL_PRI_MEM: begin
                    pipe_ctrl_pc_stall_o      = 1'b1;
                    pipe_ctrl_if2id_stall_o   = 1'b1;
                    pipe_ctrl_id2ex_stall_o   = 1'b1;
                    pipe_ctrl_ex2mem_stall_o  = 1'b1;
                    pipe_ctrl_mem2wb_bubble_o = 1'b1;
                end
                PIPE_CTRL_PRI_EX: begin
                    pipe_ctrl_pc_stall_o      = 1'b1;
                    pipe_ctrl_if2id_stall_o   = 1'b1;
                    pipe_ctrl_id2ex_stall_o   = 1'b1;
                    pipe_ctrl_ex2mem_bubble_o = 1'b1;
                end
                PIPE_CTRL_PRI_ID: begin
                    pipe_ctrl_pc_stall_o      = 1'b1;
                    pipe_ctrl_if2id_stall_o   = 1'b1;
                    pipe_ctrl_id2ex_bubble_o  = 1'b1;
                end
                PIPE_CTRL_PRI_REDIR: begin
                    pipe_ctrl_pc_redirect_o   = 1'b1;
                    pipe_ctrl_if2id_bubble_o  = 1'b1;
                end
                PIPE_CTRL_PRI_IF: begin
                    pipe_ctrl_pc_stall_o      = 1'b1;
                    pipe_ctrl_if2id_bubble_o  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A redirect while a fetch is outstanding leaves a stale response to discard
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= PIPE_CTRL_RUN;
        end else begin
            case (r_state)
                PIPE_CTRL_RUN:
                    if (w_redir_ok && pipe_ctrl_if_busy_i && !pipe_ctrl_if_valid_i)
                        r_state <= PIPE_CTRL_DROP;
                PIPE_CTRL_DROP:
                    if (!w_redir_ok && pipe_ctrl_if_valid_i)
                        r_state <= PIPE_CTRL_RUN;
                default: r_state <= PIPE_CTRL_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (pipe_ctrl_pc_stall_o && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign pipe_ctrl_stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a default-width and a 4-bit-counter instance share stimulus.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, ex_rd, mem_rd;
    logic       rs1_used, rs2_used, ex_wen, ex_lui, mem_wen, mem_read;
    logic       ex_busy, mem_req, mem_ready, if_busy, if_valid, redirect;

    logic [8:0]  obs, obs_sat;
    logic [31:0] cnt;
    logic [3:0]  cnt_sat;

    logic pc_stall, pc_redir, if2id_stall, if2id_bub, id2ex_stall, id2ex_bub;
    logic ex2mem_stall, ex2mem_bub, mem2wb_bub;
    logic s_pc_stall, s_pc_redir, s_if2id_stall, s_if2id_bub, s_id2ex_stall, s_id2ex_bub;
    logic s_ex2mem_stall, s_ex2mem_bub, s_mem2wb_bub;

    int n_cmp = 0;
    int n_err = 0;

    // {pc_stall, pc_redirect, if2id_stall, if2id_bubble, id2ex_stall, id2ex_bubble,
    //  ex2mem_stall, ex2mem_bubble, mem2wb_bubble}
    localparam logic [8:0] P_NONE  = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] P_IF    = 9'b1_0_0_1_0_0_0_0_0;
    localparam logic [8:0] P_ID    = 9'b1_0_1_0_0_1_0_0_0;
    localparam logic [8:0] P_EX    = 9'b1_0_1_0_1_0_0_1_0;
    localparam logic [8:0] P_MEM   = 9'b1_0_1_0_1_0_1_0_1;
    localparam logic [8:0] P_REDIR = 9'b0_1_0_1_0_0_0_0_0;

    always #5 clk = ~clk;

    assign obs     = {pc_stall, pc_redir, if2id_stall, if2id_bub, id2ex_stall, id2ex_bub,
                      ex2mem_stall, ex2mem_bub, mem2wb_bub};
    assign obs_sat = {s_pc_stall, s_pc_redir, s_if2id_stall, s_if2id_bub, s_id2ex_stall,
                      s_id2ex_bub, s_ex2mem_stall, s_ex2mem_bub, s_mem2wb_bub};

    pipe_ctrl u_dut (
        .clk(clk), .rst(rst),
        .pipe_ctrl_id_rs1_index_i(rs1), .pipe_ctrl_id_rs2_index_i(rs2),
        .pipe_ctrl_id_rs1_used_i(rs1_used), .pipe_ctrl_id_rs2_used_i(rs2_used),
        .pipe_ctrl_id2ex_rd_index_i(ex_rd), .pipe_ctrl_id2ex_rd_wen_i(ex_wen),
        .pipe_ctrl_id2ex_inst_lui_i(ex_lui),
        .pipe_ctrl_ex2mem_rd_index_i(mem_rd), .pipe_ctrl_ex2mem_rd_wen_i(mem_wen),
        .pipe_ctrl_ex2mem_mem_read_i(mem_read),
        .pipe_ctrl_ex_busy_i(ex_busy), .pipe_ctrl_mem_req_i(mem_req),
        .pipe_ctrl_mem_ready_i(mem_ready), .pipe_ctrl_if_busy_i(if_busy),
        .pipe_ctrl_if_valid_i(if_valid), .pipe_ctrl_id_redirect_i(redirect),
        .pipe_ctrl_pc_stall_o(pc_stall), .pipe_ctrl_pc_redirect_o(pc_redir),
        .pipe_ctrl_if2id_stall_o(if2id_stall), .pipe_ctrl_if2id_bubble_o(if2id_bub),
        .pipe_ctrl_id2ex_stall_o(id2ex_stall), .pipe_ctrl_id2ex_bubble_o(id2ex_bub),
        .pipe_ctrl_ex2mem_stall_o(ex2mem_stall), .pipe_ctrl_ex2mem_bubble_o(ex2mem_bub),
        .pipe_ctrl_mem2wb_bubble_o(mem2wb_bub), .pipe_ctrl_stall_cnt_o(cnt)
    );

    pipe_ctrl #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst),
        .pipe_ctrl_id_rs1_index_i(rs1), .pipe_ctrl_id_rs2_index_i(rs2),
        .pipe_ctrl_id_rs1_used_i(rs1_used), .pipe_ctrl_id_rs2_used_i(rs2_used),
        .pipe_ctrl_id2ex_rd_index_i(ex_rd), .pipe_ctrl_id2ex_rd_wen_i(ex_wen),
        .pipe_ctrl_id2ex_inst_lui_i(ex_lui),
        .pipe_ctrl_ex2mem_rd_index_i(mem_rd), .pipe_ctrl_ex2mem_rd_wen_i(mem_wen),
        .pipe_ctrl_ex2mem_mem_read_i(mem_read),
        .pipe_ctrl_ex_busy_i(ex_busy), .pipe_ctrl_mem_req_i(mem_req),
        .pipe_ctrl_mem_ready_i(mem_ready), .pipe_ctrl_if_busy_i(if_busy),
        .pipe_ctrl_if_valid_i(if_valid), .pipe_ctrl_id_redirect_i(redirect),
        .pipe_ctrl_pc_stall_o(s_pc_stall), .pipe_ctrl_pc_redirect_o(s_pc_redir),
        .pipe_ctrl_if2id_stall_o(s_if2id_stall), .pipe_ctrl_if2id_bubble_o(s_if2id_bub),
        .pipe_ctrl_id2ex_stall_o(s_id2ex_stall), .pipe_ctrl_id2ex_bubble_o(s_id2ex_bub),
        .pipe_ctrl_ex2mem_stall_o(s_ex2mem_stall), .pipe_ctrl_ex2mem_bubble_o(s_ex2mem_bub),
        .pipe_ctrl_mem2wb_bubble_o(s_mem2wb_bub), .pipe_ctrl_stall_cnt_o(cnt_sat)
    );

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic idle();
        rs1 = 5'd0; rs2 = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0;
        ex_rd = 5'd0; ex_wen = 1'b0; ex_lui = 1'b0;
        mem_rd = 5'd0; mem_wen = 1'b0; mem_read = 1'b0;
        ex_busy = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        if_busy = 1'b0; if_valid = 1'b1; redirect = 1'b0;
    endtask

    // Advance one clock edge; inputs are then driven 1 ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle_chk(input string tag, input logic [8:0] e);
        #1;
        chk(tag, 32'(obs), 32'(e));
    endtask

    initial begin
        idle();
        rst = 1'b1;
        mem_req = 1'b1; ex_busy = 1'b1; redirect = 1'b1; if_valid = 1'b0;
        tick();
        settle_chk("rst_outs_zero", P_NONE);
        chk("rst_sat_outs_zero", 32'(obs_sat), 32'(P_NONE));
        tick();
        chk("rst_cnt", cnt, 32'd0);
        rst = 1'b0;
        idle();
        settle_chk("idle", P_NONE);

        // Load x5 in EX, add x6,x5,x1 in ID
        ex_rd = 5'd5; ex_wen = 1'b1;
        rs1 = 5'd5; rs1_used = 1'b1; rs2 = 5'd1; rs2_used = 1'b1;
        settle_chk("ldu_c1_ex_hit", P_ID);
        tick();
        ex_rd = 5'd0; ex_wen = 1'b0;
        mem_rd = 5'd5; mem_wen = 1'b1; mem_read = 1'b1; mem_req = 1'b1; mem_ready = 1'b1;
        settle_chk("ldu_c2_mem_hit", P_ID);
        tick();
        mem_rd = 5'd0; mem_wen = 1'b0; mem_read = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        settle_chk("ldu_c3_free", P_NONE);
        chk("ldu_cnt", cnt, 32'd2);

        // LUI forwards; x0 never hits; unused source never hits
        ex_rd = 5'd5; ex_wen = 1'b1; ex_lui = 1'b1;
        settle_chk("lui_no_stall", P_NONE);
        ex_rd = 5'd0; ex_lui = 1'b0; rs1 = 5'd0;
        settle_chk("x0_no_stall", P_NONE);
        ex_rd = 5'd7; rs1 = 5'd3; rs2 = 5'd7; rs2_used = 1'b0;
        settle_chk("unused_rs2_no_stall", P_NONE);
        rs2_used = 1'b1;
        settle_chk("rs2_ex_hit", P_ID);
        idle();
        tick();

        // Memory wait of 3 cycles
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle_chk($sformatf("memwait_%0d", i), P_MEM);
            tick();
        end
        mem_ready = 1'b1;
        settle_chk("memwait_done", P_NONE);
        chk("memwait_cnt", cnt, 32'd5);
        idle();
        tick();

        // Redirect blocked by ex_busy, accepted once it falls
        ex_busy = 1'b1; redirect = 1'b1;
        settle_chk("redir_blk_0", P_EX);
        tick();
        settle_chk("redir_blk_1", P_EX);
        tick();
        ex_busy = 1'b0;
        settle_chk("redir_accept", P_REDIR);
        tick();
        redirect = 1'b0;
        settle_chk("redir_no_drop", P_NONE);
        chk("redir_cnt", cnt, 32'd7);

        // Redirect with a fetch in flight enters DROP
        if_busy = 1'b1; if_valid = 1'b0; redirect = 1'b1;
        settle_chk("drop_redir", P_REDIR);
        tick();
        redirect = 1'b0;
        settle_chk("drop_wait", P_IF);
        tick();
        if_busy = 1'b0; if_valid = 1'b1;
        settle_chk("drop_discard", P_IF);
        tick();
        settle_chk("drop_back_run", P_NONE);
        chk("drop_cnt", cnt, 32'd9);
        chk("sat_cnt_pre", 32'(cnt_sat), 32'd9);

        // 20 more stall cycles: 4-bit counter saturates at 15
        ex_busy = 1'b1;
        repeat (20) tick();
        ex_busy = 1'b0;
        #1;
        chk("sat_cnt_hold", 32'(cnt_sat), 32'd15);
        chk("wide_cnt", cnt, 32'd29);
        tick();
        chk("sat_cnt_stay", 32'(cnt_sat), 32'd15);

        // Reset while in DROP
        if_busy = 1'b1; if_valid = 1'b0; redirect = 1'b1;
        settle_chk("rdrop_redir", P_REDIR);
        tick();
        redirect = 1'b0;
        settle_chk("rdrop_in_drop", P_IF);
        rst = 1'b1; mem_req = 1'b1;
        settle_chk("rdrop_rst_outs", P_NONE);
        tick();
        chk("rdrop_cnt", cnt, 32'd0);
        chk("rdrop_sat_cnt", 32'(cnt_sat), 32'd0);
        rst = 1'b0;
        idle();
        settle_chk("rdrop_run", P_NONE);
        tick();
        chk("rdrop_cnt_idle", cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
